pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RV32I pipeline. Detects load-use hazards, taken-branch/jump redirects, instruction- and data-memory wait states. Drives the enable/flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Contains a data-memory wait FSM with a watchdog, plus saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
// Same-cycle hazard response; the FSM only tracks dmem waits for the watchdog.
module pipe_hazard_ctrl #(
  parameter int REGADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 32,
  parameter int WAIT_LIMIT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REGADDR_WIDTH-1:0] rs1_id,
  input  logic [REGADDR_WIDTH-1:0] rs2_id,
  input  logic                     rs1_used_id,
  input  logic                     rs2_used_id,
  input  logic                     memread_ex,
  input  logic [REGADDR_WIDTH-1:0] rd_ex,
  input  logic                     redirect_ex,
  input  logic                     imem_ready,
  input  logic                     dmem_req_mem,
  input  logic                     dmem_ready,
  output logic                     pc_en,
  output logic                     ifid_en,
  output logic                     ifid_flush,
  output logic                     idex_en,
  output logic                     idex_flush,
  output logic                     exmem_en,
  output logic                     memwb_flush,
  output logic                     bus_error,
  output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [CNT_WIDTH-1:0]     flush_count
);

  typedef enum logic [1:0] {RUN, DWAIT, ERR} state_e;

  state_e               state_q, state_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic                 bus_error_q, bus_error_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 lu, dwait, redirect_act;

  assign lu = memread_ex && (rd_ex != '0) &&
              ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));
  assign dwait = dmem_req_mem && !dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_error_d = bus_error_q;
    case (state_q)
      RUN: begin
        if (dwait) begin
          state_d    = DWAIT;
          wait_cnt_d = 16'd1;
        end
      end
      DWAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == 16'(WAIT_LIMIT)) begin
          state_d     = ERR;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_flush  = 1'b0;
    redirect_act = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == ERR || dwait) begin
      // Freeze: a pending redirect or load-use stays in EX/ID and is re-seen on release.
      memwb_flush = 1'b1;
    end else if (redirect_ex) begin
      redirect_act = 1'b1;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b1;
      idex_en      = 1'b1;
      idex_flush   = 1'b1;
      exmem_en     = 1'b1;
    end else if (lu) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
    end else if (!imem_ready) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && !(&stall_q)) stall_d = stall_q + 1'b1;
    if (redirect_act && !(&flush_q)) flush_d = flush_q + 1'b1;
  end

  assign bus_error    = bus_error_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
